bmu_arbiter: RTL and testbench
==============================

Name: bmu_arbiter

Overview:
Round-robin arbiter/sequencer that shares a single BMU instance between NUM_REQ requesters. Per operation it accepts one request, issues it to the BMU as a single-cycle validIn pulse, waits the fixed BMU latency, captures resultFf/error, and returns a tagged response. Sits between issue-side requesters and the BMU datapath. Only one operation is in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, requester-id width, equals clog2(NUM_REQ)
AP_W, 42, width of the packed ALU control packet (matches BMU ap)
BMU_LAT, 1, cycles from validIn high to resultFf/error valid (1..7)

Ports:
clk  input  1  clock
rstL  input  1  asynchronous active-low reset
reqValid  input  NUM_REQ  per-requester request valid
reqReady  output  NUM_REQ  per-requester accept, one-hot or zero
reqAp  input  NUM_REQ*AP_W  per-requester control packet, requester i in slice i
reqA  input  NUM_REQ*32  per-requester operand A
reqB  input  NUM_REQ*32  per-requester operand B
reqCsrRen  input  NUM_REQ  per-requester CSR read enable
reqCsrRdata  input  NUM_REQ*32  per-requester CSR read data
bmuValidIn  output  1  BMU issue strobe
bmuAp  output  AP_W  BMU control packet
bmuA  output  32  BMU aIn
bmuB  output  32  BMU bIn
bmuCsrRen  output  1  BMU csrRenIn
bmuCsrRdata  output  32  BMU csrRdataIn
bmuResultFf  input  32  BMU result
bmuError  input  1  BMU error flag
rspValid  output  1  response valid
rspReady  input  1  response accept
rspId  output  ID_W  id of the requester that owns the response
rspResult  output  32  captured result
rspError  output  1  captured error
errCount  output  16  saturating count of responses delivered with error=1
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rstL low, async): state=IDLE, rrPtr=0, and all outputs 0, including errCount. All bmu* outputs are 0 whenever bmuValidIn=0.
- Reset asserted mid-operation abandons the operation silently. No response is produced.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Winner = first i with reqValid[i] set, searching from rrPtr upward and wrapping NUM_REQ-1 -> 0.
  - reqReady[winner]=1 combinationally in the same cycle. The handshake is reqValid & reqReady.
  - Latch the winner's ap, A, B, csrRen, csrRdata and id. Go to ISSUE.
  - No reqValid: stay in IDLE with reqReady=0.
- ISSUE: bmuValidIn=1 for exactly one cycle, driving the latched operands. Load wait counter = BMU_LAT-1. Go to WAIT.
- WAIT:
  - Operands are held on bmu* outputs; bmuValidIn=0.
  - Counter decrements each cycle. On the cycle the counter equals 0, capture bmuResultFf and bmuError into rspResult/rspError. Go to RESP.
  - Capture occurs exactly BMU_LAT cycles after the bmuValidIn cycle.
- RESP:
  - rspValid=1; rspId, rspResult and rspError stay stable until rspReady.
  - On rspValid & rspReady: rspValid drops next cycle and rrPtr=(rspId+1) mod NUM_REQ.
  - If rspError=1 at handshake, errCount increments, saturating at 16'hFFFF.
  - Go to IDLE.
- reqReady is 0 in every state except IDLE.
- Minimum spacing between back-to-back operations is BMU_LAT+3 cycles, with rspReady tied high.
- reqValid dropping while the FSM is not in IDLE has no effect. Requesters must hold reqValid until accepted.
- A requester may re-request in the IDLE cycle that follows its own response. Round-robin still serves the other pending requesters first.

Optional Feature:
BMU_ARB_HIPRI_EN:
- When defined, requester 0 has fixed highest priority. If reqValid[0] is set in IDLE it wins regardless of rrPtr. rrPtr is not updated after a requester-0 grant. Requesters 1..NUM_REQ-1 are round-robin among themselves.
- When undefined, all requesters are pure round-robin as described above.

Test Plan:
- Single request: reqValid=4'b0010, ap.add, A=5, B=7, BMU model returns 12 -> bmuValidIn pulses 1 cycle after accept; rspValid with rspId=1, rspResult=32'd12, rspError=0; rrPtr=2.
- Fairness: all four requesters held valid for 8 ops, rspReady=1 -> grant order 0,1,2,3,0,1,2,3; each op takes BMU_LAT+3 cycles (4 cycles for BMU_LAT=1).
- Backpressure: rspReady=0 for 10 cycles in RESP -> rspValid, rspId, rspResult stable; reqReady=0 throughout; no second bmuValidIn.
- Error path: BMU model returns error=1 on 3 ops -> rspError=1 on each and errCount=3. Force errCount=16'hFFFE, deliver 2 more errors -> errCount=16'hFFFF.
- Reset mid-op: drop rstL during WAIT -> all outputs 0 immediately. After release, a pending reqValid=4'b1000 is granted with rspId=3 and no stale response appears.
- BMU_ARB_HIPRI_EN defined, reqValid=4'b1111 held -> requester 0 wins every grant; with reqValid[0]=0 the grant order is 1,2,3,1.

Source files
------------

// File: rtl/bmu_arbiter.sv
// bmu_arbiter: round-robin sequencer sharing one BMU between NUM_REQ requesters.
// One operation in flight: IDLE (grant/latch) -> ISSUE (validIn pulse) ->
// WAIT (BMU_LAT cycles) -> RESP (hold tagged response until rspReady).
//
// Ports:
//   clk, rstL                 clock, async active-low reset
//   reqValid/reqReady         per-requester handshake (reqReady one-hot or 0)
//   reqAp/reqA/reqB/reqCsr*   per-requester operands, requester i in slice i
//   bmuValidIn, bmu*          BMU issue strobe and operands (0 outside ISSUE/WAIT)
//   bmuResultFf, bmuError     BMU result, sampled BMU_LAT cycles after issue
//   rspValid/rspReady, rsp*   tagged response to the owning requester
//   errCount                  saturating count of error responses delivered
//   busy                      FSM not in IDLE
//
// Optional build macro: BMU_ARB_HIPRI_EN gives requester 0 fixed top priority;
// requesters 1..NUM_REQ-1 stay round-robin among themselves.
module bmu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int AP_W    = 42,
  parameter int BMU_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rstL,
  input  logic [NUM_REQ-1:0]      reqValid,
  output logic [NUM_REQ-1:0]      reqReady,
  input  logic [NUM_REQ*AP_W-1:0] reqAp,
  input  logic [NUM_REQ*32-1:0]   reqA,
  input  logic [NUM_REQ*32-1:0]   reqB,
  input  logic [NUM_REQ-1:0]      reqCsrRen,
  input  logic [NUM_REQ*32-1:0]   reqCsrRdata,
  output logic                    bmuValidIn,
  output logic [AP_W-1:0]         bmuAp,
  output logic [31:0]             bmuA,
  output logic [31:0]             bmuB,
  output logic                    bmuCsrRen,
  output logic [31:0]             bmuCsrRdata,
  input  logic [31:0]             bmuResultFf,
  input  logic                    bmuError,
  output logic                    rspValid,
  input  logic                    rspReady,
  output logic [ID_W-1:0]         rspId,
  output logic [31:0]             rspResult,
  output logic                    rspError,
  output logic [15:0]             errCount,
  output logic                    busy
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   rr_q;
  logic [ID_W-1:0]   id_q;
  logic [AP_W-1:0]   ap_q;
  logic [31:0]       a_q, b_q, rdata_q, res_q;
  logic              ren_q, err_q;
  logic [15:0]       err_cnt_q;

  logic              win_vld;
  logic [ID_W-1:0]   win_idx;
  logic              op_drv;
  logic              rsp_hs;

  // Winner search starts at rr_q and wraps; first valid requester wins.
  always_comb begin : p_win
    logic [ID_W-1:0] idx;
    win_vld = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_q) + k) % NUM_REQ);
`ifdef BMU_ARB_HIPRI_EN
      if (!win_vld && idx != '0 && reqValid[idx]) begin
`else
      if (!win_vld && reqValid[idx]) begin
`endif
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
`ifdef BMU_ARB_HIPRI_EN
    // Requester 0 overrides the round-robin result.
    if (reqValid[0]) begin
      win_vld = 1'b1;
      win_idx = '0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = ISSUE;
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(BMU_LAT - 1);
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP:    if (rspReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rsp_hs = (state_q == RESP) && rspReady;

  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rr_q      <= '0;
      id_q      <= '0;
      ap_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ren_q     <= 1'b0;
      rdata_q   <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && win_vld) begin
        id_q    <= win_idx;
        ap_q    <= reqAp[win_idx*AP_W +: AP_W];
        a_q     <= reqA[win_idx*32 +: 32];
        b_q     <= reqB[win_idx*32 +: 32];
        ren_q   <= reqCsrRen[win_idx];
        rdata_q <= reqCsrRdata[win_idx*32 +: 32];
      end
      if (state_q == WAIT && cnt_q == '0) begin
        res_q <= bmuResultFf;
        err_q <= bmuError;
      end
      if (rsp_hs) begin
`ifdef BMU_ARB_HIPRI_EN
        // Requester 0 grants leave the round-robin pointer untouched.
        if (id_q != '0)
`endif
          rr_q <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
        if (err_q && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  // Operands are visible only while the BMU owns them (ISSUE and WAIT).
  assign op_drv      = (state_q == ISSUE) || (state_q == WAIT);
  assign bmuValidIn  = (state_q == ISSUE);
  assign bmuAp       = op_drv ? ap_q    : '0;
  assign bmuA        = op_drv ? a_q     : '0;
  assign bmuB        = op_drv ? b_q     : '0;
  assign bmuCsrRen   = op_drv ? ren_q   : 1'b0;
  assign bmuCsrRdata = op_drv ? rdata_q : '0;

  assign reqReady  = (state_q == IDLE && win_vld) ? (NUM_REQ'(1) << win_idx) : '0;
  assign rspValid  = (state_q == RESP);
  assign rspId     = id_q;
  assign rspResult = res_q;
  assign rspError  = err_q;
  assign errCount  = err_cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bmu_arbiter.sv
module tb_bmu_arbiter;
  localparam int NR = 4, IDW = 2, APW = 42, LAT = 1;

  logic clk = 1'b0;
  logic rstL;
  logic [NR-1:0] reqValid, reqReady, reqCsrRen;
  logic [NR*APW-1:0] reqAp;
  logic [NR*32-1:0] reqA, reqB, reqCsrRdata;
  logic bmuValidIn, bmuCsrRen, bmuError, rspValid, rspReady, rspError, busy;
  logic [APW-1:0] bmuAp;
  logic [31:0] bmuA, bmuB, bmuCsrRdata, bmuResultFf, rspResult;
  logic [IDW-1:0] rspId;
  logic [15:0] errCount;

  int n_tests = 0, n_fail = 0, cyc = 0, issue_cnt = 0;
  logic err_inj;
  int grant_q[$];
  int gcyc_q[$];

  always #5 clk = ~clk;

  bmu_arbiter #(.NUM_REQ(NR), .ID_W(IDW), .AP_W(APW), .BMU_LAT(LAT)) dut (
    .clk(clk), .rstL(rstL),
    .reqValid(reqValid), .reqReady(reqReady), .reqAp(reqAp), .reqA(reqA), .reqB(reqB),
    .reqCsrRen(reqCsrRen), .reqCsrRdata(reqCsrRdata),
    .bmuValidIn(bmuValidIn), .bmuAp(bmuAp), .bmuA(bmuA), .bmuB(bmuB),
    .bmuCsrRen(bmuCsrRen), .bmuCsrRdata(bmuCsrRdata),
    .bmuResultFf(bmuResultFf), .bmuError(bmuError),
    .rspValid(rspValid), .rspReady(rspReady), .rspId(rspId), .rspResult(rspResult),
    .rspError(rspError), .errCount(errCount), .busy(busy)
  );

  // One-cycle BMU: add, result valid the cycle after validIn, junk otherwise.
  always @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      bmuResultFf <= '0;
      bmuError    <= 1'b0;
    end else if (bmuValidIn) begin
      bmuResultFf <= bmuA + bmuB;
      bmuError    <= err_inj;
    end else begin
      bmuResultFf <= 32'hDEAD_BEEF;
      bmuError    <= 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (rstL && bmuValidIn) issue_cnt++;
    for (int k = 0; k < NR; k++)
      if (rstL && reqValid[k] && reqReady[k]) begin
        grant_q.push_back(k);
        gcyc_q.push_back(cyc);
      end
  end

  task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b);
    reqA[idx*32 +: 32]    = a;
    reqB[idx*32 +: 32]    = b;
    reqAp[idx*APW +: APW] = APW'(idx + 1);
  endtask

  // Issues one op from an idle arbiter; returns at the negedge inside RESP.
  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b);
    set_op(idx, a, b);
    reqValid = 4'b0001 << idx;
    repeat (3) begin
      @(negedge clk);
      reqValid = '0;
    end
  endtask

  task automatic test_reset();
    rstL = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({reqReady, bmuValidIn, bmuAp, bmuA, bmuB, bmuCsrRen, bmuCsrRdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_bmu_outputs got rr=%h v=%b a=%h b=%h exp all 0", reqReady, bmuValidIn, bmuA, bmuB);
    end
    n_tests++;
    if ({rspValid, rspId, rspResult, rspError, errCount, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp_outputs got v=%b id=%0d r=%h e=%b cnt=%h busy=%b exp all 0",
               rspValid, rspId, rspResult, rspError, errCount, busy);
    end
    rstL = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    rspReady = 1'b1;
    set_op(1, 32'd5, 32'd7);
    reqValid = 4'b0010;
    #1;
    n_tests++;
    if (reqReady !== 4'b0010) begin n_fail++; $display("FAIL single_ready got %b exp 0010", reqReady); end
    @(negedge clk);
    reqValid = '0;
    #1;
    n_tests++;
    if (bmuValidIn !== 1'b1 || bmuA !== 32'd5 || bmuB !== 32'd7 || bmuAp !== 42'd2) begin
      n_fail++;
      $display("FAIL single_issue got v=%b a=%0d b=%0d ap=%0d exp v=1 a=5 b=7 ap=2", bmuValidIn, bmuA, bmuB, bmuAp);
    end
    n_tests++;
    if (reqReady !== 4'b0000 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_issue_ready got rr=%b busy=%b exp 0000/1", reqReady, busy);
    end
    @(negedge clk);
    n_tests++;
    if (bmuValidIn !== 1'b0 || rspValid !== 1'b0) begin
      n_fail++; $display("FAIL single_wait got v=%b rspv=%b exp 0/0", bmuValidIn, rspValid);
    end
    @(negedge clk);
    n_tests++;
    if (rspValid !== 1'b1 || rspId !== 2'd1 || rspResult !== 32'd12 || rspError !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rsp got v=%b id=%0d r=%0d e=%b exp 1/1/12/0", rspValid, rspId, rspResult, rspError);
    end
    n_tests++;
    if (bmuA !== 32'd0 || bmuValidIn !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp_bmu_idle got a=%h v=%b exp 0/0", bmuA, bmuValidIn);
    end
    @(negedge clk);
    n_tests++;
    if (rspValid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_done got rspv=%b busy=%b exp 0/0", rspValid, busy);
    end
    // pointer now 2: with 1 and 3 pending, 3 must win
    set_op(3, 32'd1, 32'd1);
    reqValid = 4'b1010;
    #1;
    n_tests++;
    if (reqReady !== 4'b1000) begin n_fail++; $display("FAIL single_rrptr got %b exp 1000", reqReady); end
    @(negedge clk);
    reqValid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fairness();
`ifdef BMU_ARB_HIPRI_EN
    int exp_g[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    int exp_g[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    grant_q.delete();
    gcyc_q.delete();
    rspReady = 1'b1;
    for (int i = 0; i < NR; i++) set_op(i, 32'(i * 10), 32'd1);
    reqValid = 4'b1111;
    repeat (29) @(negedge clk);
    reqValid = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (grant_q.size() != 8) begin
      n_fail++; $display("FAIL fair_count got %0d exp 8", grant_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (grant_q[i] != exp_g[i]) begin
          n_fail++; $display("FAIL fair_order[%0d] got %0d exp %0d", i, grant_q[i], exp_g[i]);
        end
        if (i > 0) begin
          n_tests++;
          if (gcyc_q[i] - gcyc_q[i-1] != LAT + 3) begin
            n_fail++; $display("FAIL fair_spacing[%0d] got %0d exp %0d", i, gcyc_q[i] - gcyc_q[i-1], LAT + 3);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int ic0;
    rspReady = 1'b0;
    set_op(2, 32'd100, 32'd23);
    reqValid = 4'b0100;
    @(negedge clk);
    reqValid = '0;
    @(negedge clk);
    ic0 = issue_cnt;
    @(negedge clk);
    set_op(0, 32'd3, 32'd4);
    reqValid = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_tests++;
      if (rspValid !== 1'b1 || rspId !== 2'd2 || rspResult !== 32'd123 || reqReady !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got v=%b id=%0d r=%0d rr=%b exp 1/2/123/0000", i, rspValid, rspId, rspResult, reqReady);
      end
      @(negedge clk);
    end
    n_tests++;
    if (issue_cnt != ic0) begin n_fail++; $display("FAIL bp_no_reissue got %0d issues exp %0d", issue_cnt, ic0); end
    rspReady = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (rspValid !== 1'b0 || reqReady !== 4'b0001) begin
      n_fail++; $display("FAIL bp_release got rspv=%b rr=%b exp 0/0001", rspValid, reqReady);
    end
    @(negedge clk);
    reqValid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_errors();
    rspReady = 1'b1;
    err_inj  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_op(1, 32'(i), 32'd2);
      n_tests++;
      if (rspError !== 1'b1 || rspResult !== 32'(i + 2)) begin
        n_fail++; $display("FAIL err_rsp[%0d] got e=%b r=%0d exp 1/%0d", i, rspError, rspResult, i + 2);
      end
      @(negedge clk);
    end
    n_tests++;
    if (errCount !== 16'd3) begin n_fail++; $display("FAIL err_count got %0d exp 3", errCount); end
    force dut.err_cnt_q = 16'hFFFE;
    #1;
    release dut.err_cnt_q;
    #1;
    n_tests++;
    if (errCount !== 16'hFFFE) begin n_fail++; $display("FAIL err_preset got %h exp fffe", errCount); end
    do_op(1, 32'd1, 32'd1);
    @(negedge clk);
    n_tests++;
    if (errCount !== 16'hFFFF) begin n_fail++; $display("FAIL err_reach_max got %h exp ffff", errCount); end
    do_op(1, 32'd1, 32'd1);
    @(negedge clk);
    n_tests++;
    if (errCount !== 16'hFFFF) begin n_fail++; $display("FAIL err_saturate got %h exp ffff", errCount); end
    err_inj = 1'b0;
  endtask

  task automatic test_reset_midop();
    rspReady = 1'b1;
    set_op(0, 32'd9, 32'd9);
    reqValid = 4'b0001;
    @(negedge clk);
    reqValid = '0;
    @(negedge clk);
    #1;
    rstL = 1'b0;
    #1;
    n_tests++;
    if ({busy, bmuValidIn, bmuA, bmuB, rspValid, reqReady, errCount} !== '0) begin
      n_fail++;
      $display("FAIL midop_reset got busy=%b v=%b a=%h rspv=%b cnt=%h exp all 0", busy, bmuValidIn, bmuA, rspValid, errCount);
    end
    set_op(3, 32'd40, 32'd2);
    reqValid = 4'b1000;
    @(negedge clk);
    rstL = 1'b1;
    #1;
    n_tests++;
    if (reqReady !== 4'b1000) begin n_fail++; $display("FAIL midop_regrant got %b exp 1000", reqReady); end
    @(negedge clk);
    reqValid = '0;
    n_tests++;
    if (rspValid !== 1'b0) begin n_fail++; $display("FAIL midop_stale_issue got rspv=%b exp 0", rspValid); end
    @(negedge clk);
    n_tests++;
    if (rspValid !== 1'b0) begin n_fail++; $display("FAIL midop_stale_wait got rspv=%b exp 0", rspValid); end
    @(negedge clk);
    n_tests++;
    if (rspValid !== 1'b1 || rspId !== 2'd3 || rspResult !== 32'd42) begin
      n_fail++; $display("FAIL midop_rsp got v=%b id=%0d r=%0d exp 1/3/42", rspValid, rspId, rspResult);
    end
    @(negedge clk);
  endtask

`ifdef BMU_ARB_HIPRI_EN
  task automatic test_hipri();
    int exp_g[8] = '{0, 0, 0, 0, 1, 2, 3, 1};
    grant_q.delete();
    gcyc_q.delete();
    rspReady = 1'b1;
    for (int i = 0; i < NR; i++) set_op(i, 32'd1, 32'(i));
    reqValid = 4'b1111;
    repeat (13) @(negedge clk);
    reqValid = 4'b1110;
    repeat (16) @(negedge clk);
    reqValid = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (grant_q.size() != 8) begin
      n_fail++; $display("FAIL hipri_count got %0d exp 8", grant_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (grant_q[i] != exp_g[i]) begin
          n_fail++; $display("FAIL hipri_order[%0d] got %0d exp %0d", i, grant_q[i], exp_g[i]);
        end
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rstL        = 1'b0;
    reqValid    = '0;
    reqAp       = '0;
    reqA        = '0;
    reqB        = '0;
    reqCsrRen   = '0;
    reqCsrRdata = '0;
    rspReady    = 1'b1;
    err_inj     = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_errors();
    test_reset_midop();
`ifdef BMU_ARB_HIPRI_EN
    test_hipri();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
